// File: rtl/mem_arb_pkg.sv
// Shared constants, FSM state encoding and write-buffer entry type for the
// two-cache main-memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W   = 13;
  localparam int LINE_W   = 32;
  localparam int WDATA_W  = 8;
  localparam int WB_DEPTH = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WR     = 2'd1;
  localparam logic [1:0] ST_RD     = 2'd2;
  localparam logic [1:0] ST_RD_END = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [WDATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wr_buf.sv
// Per-port write-through buffer: a small FIFO of {address, byte} entries.
// A push into a full buffer still succeeds when the same edge pops an entry;
// otherwise the write is lost and the sticky overflow flag is raised.
module wr_buf
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_push,
  input  wb_entry_t i_entry,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_empty,
  output logic      o_full,
  output logic      o_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic w_doPop;
  logic w_doPush;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_CNT);
  assign o_head   = r_mem[r_rdPtr];
  assign o_ovf    = r_ovf;
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_entry;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy, ovf is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && !w_doPush) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache (port 0) and D-cache
// (port 1). Buffered write-through data always drains before a refill read is
// issued, so a refill can never return data older than a buffered write.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               c0_rreq,
  input  logic [ADDR_W-1:0]  c0_raddr,
  output logic [LINE_W-1:0]  c0_rdata,
  output logic               c0_rvalid,
  input  logic               c0_wreq,
  input  logic [ADDR_W-1:0]  c0_waddr,
  input  logic [WDATA_W-1:0] c0_wdata,
  output logic               c0_wfull,
  output logic               c0_wovf,
  input  logic               c1_rreq,
  input  logic [ADDR_W-1:0]  c1_raddr,
  output logic [LINE_W-1:0]  c1_rdata,
  output logic               c1_rvalid,
  input  logic               c1_wreq,
  input  logic [ADDR_W-1:0]  c1_waddr,
  input  logic [WDATA_W-1:0] c1_wdata,
  output logic               c1_wfull,
  output logic               c1_wovf,
  output logic               mem_rreq,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_rvalid,
  output logic               mem_wreq,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WDATA_W-1:0] mem_wdata,
  input  logic               mem_wack
);

  logic [1:0]         r_state;
  logic               r_gnt;
  logic               r_wrPort;
  logic               r_rrWr;
  logic               r_rrRd;
  logic               r_memRreq;
  logic [ADDR_W-1:0]  r_memRaddr;
  logic               r_memWreq;
  logic [ADDR_W-1:0]  r_memWaddr;
  logic [WDATA_W-1:0] r_memWdata;

  wb_entry_t w_head0;
  wb_entry_t w_head1;
  wb_entry_t w_selHead;
  logic      w_empty0;
  logic      w_empty1;
  logic      w_pop0;
  logic      w_pop1;
  logic      w_wrSel;
  logic      w_rdSel;

  // Port 0 write buffer
  wr_buf #(.DEPTH(WB_DEPTH)) u_wbuf0 (
    .clk     (clk),
    .reset   (reset),
    .i_push  (c0_wreq),
    .i_entry ({c0_waddr, c0_wdata}),
    .i_pop   (w_pop0),
    .o_head  (w_head0),
    .o_empty (w_empty0),
    .o_full  (c0_wfull),
    .o_ovf   (c0_wovf)
  );

  // Port 1 write buffer
  wr_buf #(.DEPTH(WB_DEPTH)) u_wbuf1 (
    .clk     (clk),
    .reset   (reset),
    .i_push  (c1_wreq),
    .i_entry ({c1_waddr, c1_wdata}),
    .i_pop   (w_pop1),
    .o_head  (w_head1),
    .o_empty (w_empty1),
    .o_full  (c1_wfull),
    .o_ovf   (c1_wovf)
  );

  // Round-robin choices: favour the pointed-to port, fall back to the other.
  assign w_wrSel   = r_rrWr ? !w_empty1 : w_empty0;
  assign w_rdSel   = r_rrRd ? c1_rreq : !c0_rreq;
  assign w_selHead = w_wrSel ? w_head1 : w_head0;

  // A buffer entry retires on the edge memory accepts it.
  assign w_pop0 = (r_state == ST_WR) && mem_wack && !r_wrPort;
  assign w_pop1 = (r_state == ST_WR) && mem_wack &&  r_wrPort;

  assign c0_rdata  = mem_rdata;
  assign c1_rdata  = mem_rdata;
  assign c0_rvalid = mem_rvalid && (r_state == ST_RD) && !r_gnt;
  assign c1_rvalid = mem_rvalid && (r_state == ST_RD) &&  r_gnt;

  assign mem_rreq  = r_memRreq;
  assign mem_raddr = r_memRaddr;
  assign mem_wreq  = r_memWreq;
  assign mem_waddr = r_memWaddr;
  assign mem_wdata = r_memWdata;

  // Arbiter FSM: drain writes first, then serve one refill at a time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 1'b0;
      r_wrPort   <= 1'b0;
      r_rrWr     <= 1'b0;
      r_rrRd     <= 1'b0;
      r_memRreq  <= 1'b0;
      r_memRaddr <= '0;
      r_memWreq  <= 1'b0;
      r_memWaddr <= '0;
      r_memWdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty0 || !w_empty1) begin
            r_wrPort   <= w_wrSel;
            r_memWaddr <= w_selHead.addr;
            r_memWdata <= w_selHead.data;
            r_memWreq  <= 1'b1;
            r_state    <= ST_WR;
          end else if (c0_rreq || c1_rreq) begin
            r_gnt      <= w_rdSel;
            r_memRaddr <= w_rdSel ? c1_raddr : c0_raddr;
            r_memRreq  <= 1'b1;
            r_state    <= ST_RD;
          end
        end
        ST_WR: begin
          if (mem_wack) begin
            r_memWreq <= 1'b0;
            r_rrWr    <= ~r_wrPort;
            r_state   <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (mem_rvalid) begin
            r_memRreq <= 1'b0;
            r_rrRd    <= ~r_gnt;
            r_state   <= ST_RD_END;
          end
        end
        ST_RD_END: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the bench plays the
// part of both caches and the main memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               c0_rreq, c1_rreq;
  logic [ADDR_W-1:0]  c0_raddr, c1_raddr;
  logic [LINE_W-1:0]  c0_rdata, c1_rdata;
  logic               c0_rvalid, c1_rvalid;
  logic               c0_wreq, c1_wreq;
  logic [ADDR_W-1:0]  c0_waddr, c1_waddr;
  logic [WDATA_W-1:0] c0_wdata, c1_wdata;
  logic               c0_wfull, c1_wfull, c0_wovf, c1_wovf;
  logic               mem_rreq, mem_wreq, mem_rvalid, mem_wack;
  logic [ADDR_W-1:0]  mem_raddr, mem_waddr;
  logic [LINE_W-1:0]  mem_rdata;
  logic [WDATA_W-1:0] mem_wdata;

  int nVectors = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_rreq(c0_rreq), .c0_raddr(c0_raddr), .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid),
    .c0_wreq(c0_wreq), .c0_waddr(c0_waddr), .c0_wdata(c0_wdata), .c0_wfull(c0_wfull), .c0_wovf(c0_wovf),
    .c1_rreq(c1_rreq), .c1_raddr(c1_raddr), .c1_rdata(c1_rdata), .c1_rvalid(c1_rvalid),
    .c1_wreq(c1_wreq), .c1_waddr(c1_waddr), .c1_wdata(c1_wdata), .c1_wfull(c1_wfull), .c1_wovf(c1_wovf),
    .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wreq(mem_wreq), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wack(mem_wack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Memory side of one refill: wait for mem_rreq, answer, report who was strobed.
  task automatic serve_read(input logic [LINE_W-1:0] data, output logic sawV0,
                            output logic sawV1, output logic [ADDR_W-1:0] addr,
                            output logic timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < 20 && timedOut; i++) begin
      if (mem_rreq) timedOut = 1'b0;
      else tick();
    end
    addr       = mem_raddr;
    mem_rdata  = data;
    mem_rvalid = 1'b1;
    #1;
    sawV0 = c0_rvalid;
    sawV1 = c1_rvalid;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    nVectors++;
    if (mem_rreq !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_mem_rreq: got %b want 0", mem_rreq); end
    nVectors++;
    if (mem_wreq !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_mem_wreq: got %b want 0", mem_wreq); end
    nVectors++;
    if ({c0_wfull, c1_wfull, c0_wovf, c1_wovf} !== 4'b0000) begin
      nMiscompares++; $display("[TB] FAIL reset_flags: got %b want 0000", {c0_wfull, c1_wfull, c0_wovf, c1_wovf});
    end
  endtask

  task automatic test_single_read();
    logic early;
    c0_raddr = 13'h0A4;
    c0_rreq  = 1'b1;
    tick();
    nVectors++;
    if (mem_rreq !== 1'b1) begin nMiscompares++; $display("[TB] FAIL rd1_mem_rreq: got %b want 1", mem_rreq); end
    nVectors++;
    if (mem_raddr !== 13'h0A4) begin nMiscompares++; $display("[TB] FAIL rd1_mem_raddr: got %h want 0a4", mem_raddr); end
    early = 1'b0;
    repeat (4) begin
      if (c0_rvalid || c1_rvalid) early = 1'b1;
      tick();
    end
    nVectors++;
    if (early !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rd1_early_rvalid: got %b want 0", early); end
    mem_rdata  = 32'hDEADBEEF;
    mem_rvalid = 1'b1;
    #1;
    nVectors++;
    if ({c0_rvalid, c1_rvalid} !== 2'b10) begin nMiscompares++; $display("[TB] FAIL rd1_rvalid: got %b want 10", {c0_rvalid, c1_rvalid}); end
    nVectors++;
    if (c0_rdata !== 32'hDEADBEEF) begin nMiscompares++; $display("[TB] FAIL rd1_rdata: got %h want deadbeef", c0_rdata); end
    tick();
    mem_rvalid = 1'b0;
    c0_rreq    = 1'b0;
    #1;
    nVectors++;
    if ({mem_rreq, c0_rvalid} !== 2'b00) begin nMiscompares++; $display("[TB] FAIL rd1_done: got %b want 00", {mem_rreq, c0_rvalid}); end
    tick();
  endtask

  task automatic test_contention();
    logic v0, v1, tmo;
    logic [ADDR_W-1:0] a;
    apply_reset();
    c0_raddr = 13'h100; c1_raddr = 13'h200;
    c0_rreq = 1'b1; c1_rreq = 1'b1;
    serve_read(32'h11110000, v0, v1, a, tmo);
    nVectors++;
    if ({tmo, v0, v1, a} !== {1'b0, 1'b1, 1'b0, 13'h100}) begin
      nMiscompares++; $display("[TB] FAIL rr_first: got tmo=%b v=%b%b addr=%h want tmo=0 v=10 addr=100", tmo, v0, v1, a);
    end
    c0_rreq = 1'b0;
    tick();
    c0_raddr = 13'h110; c0_rreq = 1'b1;
    serve_read(32'h22221111, v0, v1, a, tmo);
    nVectors++;
    if ({tmo, v0, v1, a} !== {1'b0, 1'b0, 1'b1, 13'h200}) begin
      nMiscompares++; $display("[TB] FAIL rr_repeat: got tmo=%b v=%b%b addr=%h want tmo=0 v=01 addr=200", tmo, v0, v1, a);
    end
    nVectors++;
    if (c1_rdata !== 32'h22221111) begin nMiscompares++; $display("[TB] FAIL rr_c1_rdata: got %h want 22221111", c1_rdata); end
    c1_rreq = 1'b0;
    serve_read(32'h33332222, v0, v1, a, tmo);
    nVectors++;
    if ({tmo, v0, v1, a} !== {1'b0, 1'b1, 1'b0, 13'h110}) begin
      nMiscompares++; $display("[TB] FAIL rr_third: got tmo=%b v=%b%b addr=%h want tmo=0 v=10 addr=110", tmo, v0, v1, a);
    end
    c0_rreq = 1'b0;
    tick();
  endtask

  task automatic test_write_before_read();
    logic v0, v1, tmo;
    logic [ADDR_W-1:0] a;
    c1_waddr = 13'h1F3; c1_wdata = 8'h5A; c1_wreq = 1'b1;
    tick();
    c1_wreq = 1'b0;
    c1_raddr = 13'h0C0; c1_rreq = 1'b1;
    tick();
    nVectors++;
    if ({mem_wreq, mem_waddr, mem_wdata, mem_rreq} !== {1'b1, 13'h1F3, 8'h5A, 1'b0}) begin
      nMiscompares++; $display("[TB] FAIL wbr_write: got wreq=%b addr=%h data=%h rreq=%b want 1 1f3 5a 0", mem_wreq, mem_waddr, mem_wdata, mem_rreq);
    end
    tick();
    tick();
    nVectors++;
    if ({mem_wreq, mem_rreq} !== 2'b10) begin nMiscompares++; $display("[TB] FAIL wbr_hold: got wreq,rreq=%b want 10", {mem_wreq, mem_rreq}); end
    mem_wack = 1'b1;
    tick();
    mem_wack = 1'b0;
    nVectors++;
    if ({mem_wreq, mem_rreq} !== 2'b00) begin nMiscompares++; $display("[TB] FAIL wbr_after_ack: got wreq,rreq=%b want 00", {mem_wreq, mem_rreq}); end
    tick();
    nVectors++;
    if ({mem_rreq, mem_raddr} !== {1'b1, 13'h0C0}) begin
      nMiscompares++; $display("[TB] FAIL wbr_read: got rreq=%b addr=%h want 1 0c0", mem_rreq, mem_raddr);
    end
    serve_read(32'hCAFEF00D, v0, v1, a, tmo);
    nVectors++;
    if ({tmo, v0, v1} !== 3'b001) begin nMiscompares++; $display("[TB] FAIL wbr_rvalid: got tmo,v0,v1=%b want 001", {tmo, v0, v1}); end
    c1_rreq = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    logic tmo;
    for (int i = 0; i < 5; i++) begin
      c0_waddr = 13'(13'h010 + i);
      c0_wdata = 8'(8'hA0 + i);
      c0_wreq  = 1'b1;
      tick();
      if (i == 3) begin
        nVectors++;
        if ({c0_wfull, c0_wovf} !== 2'b10) begin nMiscompares++; $display("[TB] FAIL ovf_full4: got full,ovf=%b want 10", {c0_wfull, c0_wovf}); end
      end
    end
    c0_wreq = 1'b0;
    nVectors++;
    if ({c0_wfull, c0_wovf} !== 2'b11) begin nMiscompares++; $display("[TB] FAIL ovf_drop5: got full,ovf=%b want 11", {c0_wfull, c0_wovf}); end
    for (int j = 0; j < 4; j++) begin
      tmo = 1'b1;
      for (int k = 0; k < 5 && tmo; k++) begin
        if (mem_wreq) tmo = 1'b0;
        else tick();
      end
      nVectors++;
      if ({tmo, mem_waddr, mem_wdata} !== {1'b0, 13'(13'h010 + j), 8'(8'hA0 + j)}) begin
        nMiscompares++;
        $display("[TB] FAIL ovf_drain%0d: got tmo=%b addr=%h data=%h want 0 %h %h", j, tmo, mem_waddr, mem_wdata, 13'(13'h010 + j), 8'(8'hA0 + j));
      end
      mem_wack = 1'b1;
      tick();
      mem_wack = 1'b0;
    end
    tick();
    nVectors++;
    if ({mem_wreq, c0_wfull, c0_wovf} !== 3'b001) begin
      nMiscompares++; $display("[TB] FAIL ovf_empty: got wreq,full,ovf=%b want 001", {mem_wreq, c0_wfull, c0_wovf});
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0]  gotA [4];
    logic [WDATA_W-1:0] gotD [4];
    logic [ADDR_W-1:0]  expA [4];
    logic [WDATA_W-1:0] expD [4];
    int nGot;
    expA = '{13'h020, 13'h030, 13'h021, 13'h031};
    expD = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_reset();
    nVectors++;
    if (c0_wovf !== 1'b0) begin nMiscompares++; $display("[TB] FAIL b2b_ovf_cleared: got %b want 0", c0_wovf); end
    mem_wack = 1'b1;
    c0_waddr = 13'h020; c0_wdata = 8'h11; c0_wreq = 1'b1;
    c1_waddr = 13'h030; c1_wdata = 8'h22; c1_wreq = 1'b1;
    tick();
    c0_waddr = 13'h021; c0_wdata = 8'h33;
    c1_waddr = 13'h031; c1_wdata = 8'h44;
    tick();
    c0_wreq = 1'b0; c1_wreq = 1'b0;
    nGot = 0;
    for (int t = 0; t < 12; t++) begin
      if (mem_wreq) begin
        if (nGot < 4) begin
          gotA[nGot] = mem_waddr;
          gotD[nGot] = mem_wdata;
        end
        nGot++;
      end
      tick();
    end
    mem_wack = 1'b0;
    nVectors++;
    if (nGot != 4) begin nMiscompares++; $display("[TB] FAIL b2b_count: got %0d writes want 4", nGot); end
    for (int i = 0; i < 4; i++) begin
      nVectors++;
      if ({gotA[i], gotD[i]} !== {expA[i], expD[i]}) begin
        nMiscompares++; $display("[TB] FAIL b2b_order%0d: got %h/%h want %h/%h", i, gotA[i], gotD[i], expA[i], expD[i]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic v0, v1, tmo;
    logic [ADDR_W-1:0] a;
    c0_raddr = 13'h0EE; c0_rreq = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    nVectors++;
    if ({mem_rreq, mem_raddr, mem_wreq, c0_wfull, c1_wfull} !== {1'b0, 13'h000, 1'b0, 1'b0, 1'b0}) begin
      nMiscompares++; $display("[TB] FAIL rst_rd_outputs: got rreq=%b raddr=%h wreq=%b full=%b%b want all 0", mem_rreq, mem_raddr, mem_wreq, c0_wfull, c1_wfull);
    end
    reset = 1'b0;
    c0_rreq = 1'b0;
    mem_rdata = 32'h12345678;
    mem_rvalid = 1'b1;
    #1;
    nVectors++;
    if (c0_rvalid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_rd_stale_rvalid: got %b want 0", c0_rvalid); end
    mem_rvalid = 1'b0;
    tick();
    c1_raddr = 13'h155; c1_rreq = 1'b1;
    serve_read(32'h0BADF00D, v0, v1, a, tmo);
    nVectors++;
    if ({tmo, v0, v1, a} !== {1'b0, 1'b0, 1'b1, 13'h155}) begin
      nMiscompares++; $display("[TB] FAIL rst_rd_new_read: got tmo=%b v=%b%b addr=%h want 0 01 155", tmo, v0, v1, a);
    end
    c1_rreq = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    c0_rreq = 1'b0; c1_rreq = 1'b0; c0_raddr = '0; c1_raddr = '0;
    c0_wreq = 1'b0; c1_wreq = 1'b0; c0_waddr = '0; c1_waddr = '0;
    c0_wdata = '0; c1_wdata = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_before_read();
    test_overflow();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
